// File: rtl/zephyr_pkg.sv
// Shared widths, FSM state encoding, opcodes and instruction-field helpers
// for the zephyr accumulator CPU.
package zephyr_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RIDX_W    = 2;
    localparam int STATE_W   = 3;
    localparam int RAM_DEPTH = 1 << ADDR_W;
    localparam int RF_DEPTH  = 1 << RIDX_W;

    // Codes 6 and 7 are unused; the FSM treats them as a return to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXECUTE  = 3'd2,
        S_MEMREAD  = 3'd3,
        S_MEMWRITE = 3'd4,
        S_REGWRITE = 3'd5
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_STR  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    // Instruction layout: [7:6] opcode, [5:4] register, [3:0] RAM address.
    function automatic logic [1:0] ir_op(input logic [DATA_W-1:0] ir);
        return ir[7:6];
    endfunction

    function automatic logic [RIDX_W-1:0] ir_reg(input logic [DATA_W-1:0] ir);
        return ir[5:4];
    endfunction

    function automatic logic [ADDR_W-1:0] ir_addr(input logic [DATA_W-1:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/zephyr_if.sv
// Memory bus between the CPU core and its unified program/data RAM.
interface zephyr_if;
    import zephyr_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
    logic              we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/zephyr_ram.sv
// 16x8 unified RAM: combinational read, synchronous write, never reset so
// a preloaded program survives the CPU reset.
module zephyr_ram
    import zephyr_pkg::*;
(
    input logic      CLK,
    zephyr_if.slave  bus
);

    logic [DATA_W-1:0] registers [0:RAM_DEPTH-1];

    assign bus.rdata = registers[bus.addr];

    // Single write port, strobed by the core only in MEMWRITE.
    always_ff @(posedge CLK) begin
        if (bus.we) begin
            registers[bus.addr] <= bus.wdata;
        end
    end

endmodule

// File: rtl/zephyr_regfile.sv
// 4x8 register file: one synchronous write port, one combinational read
// port, cleared by the asynchronous reset.
module zephyr_regfile
    import zephyr_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] registers [0:RF_DEPTH-1];

    assign rdata = registers[raddr];

    // Register write with asynchronous clear of all entries.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (we) begin
            registers[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/zephyr.sv
// zephyr: multi-cycle 8-bit CPU. FETCH/DECODE/EXECUTE then optionally
// MEMREAD+REGWRITE (LOAD) or MEMWRITE (STR). Holds the FSM, PC, IR, MDR
// and the RAM address mux; RAM and register file are sub-modules.
module zephyr
    import zephyr_pkg::*;
(
    input logic CLK,
    input logic RESET
);

    state_t            zstate;
    state_t            next_state;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] MDR;
    logic [ADDR_W-1:0] RAM_ADDR;

    logic [1:0]        op;
    logic [RIDX_W-1:0] ridx;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] reg_rdata;
    logic              ram_we;
    logic              rf_we;

    zephyr_if ram_bus ();

    assign op    = ir_op(IR);
    assign ridx  = ir_reg(IR);
    assign iaddr = ir_addr(IR);

    // Instruction fetch uses PC; every other state addresses the operand.
    always_comb begin
        RAM_ADDR = iaddr;
        if (zstate == S_FETCH) begin
            RAM_ADDR = PC;
        end
    end

    // Write strobes are state-decoded. The RAM has no reset of its own, so
    // RESET also masks its strobe: a reset landing in MEMWRITE must abort
    // the store rather than let it complete on the next edge.
    assign ram_we = (zstate == S_MEMWRITE) && !RESET;
    assign rf_we  = (zstate == S_REGWRITE);

    assign ram_bus.addr  = RAM_ADDR;
    assign ram_bus.wdata = reg_rdata;
    assign ram_bus.we    = ram_we;

    zephyr_ram ram_inst (
        .CLK (CLK),
        .bus (ram_bus)
    );

    zephyr_regfile register_file (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (rf_we),
        .waddr (ridx),
        .wdata (MDR),
        .raddr (ridx),
        .rdata (reg_rdata)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            zstate <= S_FETCH;
        end else begin
            zstate <= next_state;
        end
    end

    // Next-state decode; unused encodings fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (zstate)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: begin
                case (op)
                    OP_LOAD: next_state = S_MEMREAD;
                    OP_STR:  next_state = S_MEMWRITE;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMREAD:  next_state = S_REGWRITE;
            S_MEMWRITE: next_state = S_FETCH;
            S_REGWRITE: next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Datapath registers: IR/PC on fetch, PC on jump, MDR on memory read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC  <= '0;
            IR  <= '0;
            MDR <= '0;
        end else begin
            case (zstate)
                S_FETCH: begin
                    IR <= ram_bus.rdata;
                    PC <= PC + 1'b1;
                end
                S_EXECUTE: begin
                    if (op == OP_JMP) begin
                        PC <= iaddr;
                    end
                end
                S_MEMREAD: begin
                    MDR <= ram_bus.rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zephyr.sv
// Bench for zephyr: an instruction-level reference model predicts the
// architectural state after each instruction; predictions are queued and a
// monitor compares them whenever the CPU returns to FETCH.
`timescale 1ns/1ps
module tb_zephyr;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    zephyr dut (
        .CLK   (CLK),
        .RESET (RESET)
    );

    typedef struct packed {
        logic [3:0]   pc;
        logic [31:0]  regs;
        logic [127:0] ram;
        logic [3:0]   addr;
        logic [3:0]   cyc;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;

    logic [7:0] prog  [16];
    logic [7:0] m_ram [16];
    logic [7:0] m_reg [4];
    logic [3:0] m_pc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dut_ram();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = dut.ram_inst.registers[i];
        return r;
    endfunction

    function automatic logic [31:0] dut_regs();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = dut.register_file.registers[i];
        return r;
    endfunction

    // Executes one instruction of the architectural model.
    function automatic exp_t model_step();
        exp_t       e;
        logic [7:0] ins;
        logic [1:0] r;
        logic [3:0] a;
        ins  = m_ram[m_pc];
        r    = ins[5:4];
        a    = ins[3:0];
        m_pc = 4'((m_pc + 1) % 16);
        e    = '0;
        e.addr = a;
        case (ins[7:6])
            2'd1: begin m_reg[r] = m_ram[a]; e.cyc = 4'd5; end
            2'd2: begin m_ram[a] = m_reg[r]; e.cyc = 4'd4; end
            2'd3: begin m_pc = a;            e.cyc = 4'd3; end
            default:                         e.cyc = 4'd3;
        endcase
        e.pc = m_pc;
        for (int i = 0; i < 4; i++)  e.regs[i*8 +: 8] = m_reg[i];
        for (int i = 0; i < 16; i++) e.ram[i*8 +: 8]  = m_ram[i];
        return e;
    endfunction

    // Holds reset, preloads RAM and model, checks the reset state.
    task automatic reset_load();
        RESET  = 1'b1;
        mon_en = 1'b0;
        sbq.delete();
        @(negedge CLK);
        for (int i = 0; i < 16; i++) begin
            dut.ram_inst.registers[i] = prog[i];
            m_ram[i] = prog[i];
        end
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pc = 4'd0;
        @(posedge CLK);
        #1;
        check("rst_zstate", dut.zstate, 3'd0);
        check("rst_pc",     dut.PC,     4'd0);
        check("rst_ir",     dut.IR,     8'h00);
        check("rst_mdr",    dut.MDR,    8'h00);
        check("rst_regs",   dut_regs(), 32'h0);
    endtask

    task automatic release_rst();
        @(posedge CLK);
        #2;
        RESET = 1'b0;
    endtask

    // Runs n instructions through the scoreboard.
    task automatic run_sb(input int n);
        int budget;
        reset_load();
        for (int k = 0; k < n; k++) sbq.push_back(model_step());
        @(posedge CLK);
        #2;
        RESET  = 1'b0;
        mon_en = 1'b1;
        budget = 6 * n + 10;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d instructions not retired", sbq.size());
            sbq.delete();
        end
        mon_en = 1'b0;
    endtask

    // Monitor: counts cycles per instruction, compares on each return to FETCH.
    initial begin
        bit   started = 1'b0;
        int   cnt     = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!mon_en || RESET) begin
                started = 1'b0;
                cnt     = 0;
            end else if (!started) begin
                started = 1'b1;
                cnt     = 0;
            end else if (dut.zstate == 3'd0) begin
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("cycles",   4'(cnt + 1),  e.cyc);
                    check("pc",       dut.PC,       e.pc);
                    check("regs",     dut_regs(),   e.regs);
                    check("ram",      dut_ram(),    e.ram);
                    check("addr_fet", dut.RAM_ADDR, e.pc);
                end
                cnt = 0;
            end else begin
                cnt++;
                if (sbq.size() > 0) check("addr_op", dut.RAM_ADDR, sbq[0].addr);
            end
        end
    end

    initial begin
        int budget;

        // Reference program with fixed cycle-accurate checkpoints.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h4F; prog[1] = 8'h8D; prog[2] = 8'h5E; prog[3] = 8'h9C;
        prog[14] = 8'hFA; prog[15] = 8'hFF;
        reset_load();
        release_rst();
        repeat (5) @(posedge CLK);
        #1;
        check("c5_r0",     dut.register_file.registers[0], 8'hFF);
        repeat (4) @(posedge CLK);
        #1;
        check("c9_ram13",  dut.ram_inst.registers[13], 8'hFF);
        repeat (5) @(posedge CLK);
        #1;
        check("c14_r1",    dut.register_file.registers[1], 8'hFA);
        repeat (4) @(posedge CLK);
        #1;
        check("c18_ram12", dut.ram_inst.registers[12], 8'hFA);
        check("c18_pc",    dut.PC,     4'd4);
        check("c18_state", dut.zstate, 3'd0);

        // Same program through the scoreboard.
        run_sb(4);

        // NOP + JMP 0 loop.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[1] = 8'hC0;
        run_sb(10);

        // All NOPs: PC wraps 15 -> 0.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        run_sb(20);

        // Self-modifying program.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h4F; prog[1] = 8'h81; prog[15] = 8'hC0;
        run_sb(20);

        // Reset asserted during MEMWRITE aborts the store.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h4F; prog[1] = 8'h8D; prog[13] = 8'h33; prog[15] = 8'hFF;
        reset_load();
        release_rst();
        budget = 20;
        do begin
            @(negedge CLK);
            budget--;
        end while (dut.zstate != 3'd4 && budget > 0);
        check("reach_memwrite", dut.zstate, 3'd4);
        #1;
        RESET = 1'b1;
        #1;
        check("arst_zstate", dut.zstate,   3'd0);
        check("arst_pc",     dut.PC,       4'd0);
        check("arst_regs",   dut_regs(),   32'h0);
        check("arst_addr",   dut.RAM_ADDR, 4'd0);
        @(posedge CLK);
        #1;
        check("arst_ram13",  dut.ram_inst.registers[13], 8'h33);

        // Random programs.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            run_sb(30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
